// File: rtl/crc_pkg.sv
// Shared definitions for the CRC engine: FSM state encoding, algorithm presets
// and a width-generic bit-reversal helper.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_t;

    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic        refin;
        logic        refout;
        logic [31:0] xorout;
    } crc_preset_t;

    localparam crc_preset_t CRC8_MAXIM = '{
        poly: 32'h0000_0031, init: 32'h0, refin: 1'b1, refout: 1'b1, xorout: 32'h0
    };

    localparam crc_preset_t CRC16_ARC = '{
        poly: 32'h0000_8005, init: 32'h0, refin: 1'b1, refout: 1'b1, xorout: 32'h0
    };

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] reflect(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = {<<{v}};
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC advance: applies BPC serial bit steps in one cycle.
// i_bits[BPC-1] is the first bit fed into the register.
module crc_step #(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = 'h31,
    parameter int               BPC   = 1
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic [BPC-1:0]   i_bits,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] w_v;

    always_comb begin
        w_v = i_crc;
        for (int k = BPC - 1; k >= 0; k--) begin
            if (w_v[CRC_W-1] ^ i_bits[k]) begin
                w_v = (w_v << 1) ^ POLY;
            end else begin
                w_v = w_v << 1;
            end
        end
        o_crc = w_v;
    end

endmodule

// File: rtl/crc_lfsr_engine.sv
// Parametrised multi-cycle CRC engine for word streams: one word per N+1 cycles,
// transformed result and residue check published on a one-cycle pulse.
module crc_lfsr_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC8_MAXIM.poly),
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter bit               REFIN     = 1'b1,
    parameter bit               REFOUT    = 1'b1,
    parameter logic [CRC_W-1:0] XOROUT    = '0,
    parameter logic [CRC_W-1:0] CHECK_RES = '0,
    parameter int               DATA_W    = 8,
    parameter int               BPC       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic              crc_ok,
    output logic              busy
);

    localparam int N     = DATA_W / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (BPC < 1 || (DATA_W % BPC) != 0) begin : g_bad_bpc
            $error("crc_lfsr_engine: DATA_W must be a multiple of BPC");
        end
        if (CRC_W < 2 || CRC_W > 32) begin : g_bad_width
            $error("crc_lfsr_engine: CRC_W must be within 2..32");
        end
    endgenerate

    crc_state_t        r_state;
    logic [CRC_W-1:0]  r_lfsr;
    logic [DATA_W-1:0] r_shift;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [CRC_W-1:0]  r_crc_out;
    logic              r_crc_ok;
    logic              r_crc_valid;

    logic [BPC-1:0]    w_chunk;
    logic [DATA_W-1:0] w_shift_next;
    logic [CRC_W-1:0]  w_lfsr_next;
    logic [CRC_W-1:0]  w_trans;

    // The step block always consumes its MSB first, so LSB-first words are
    // presented with the low chunk bit-reversed.
    generate
        if (REFIN) begin : g_lsb_first
            assign w_chunk      = BPC'(reflect(32'(r_shift[BPC-1:0]), BPC));
            assign w_shift_next = r_shift >> BPC;
        end else begin : g_msb_first
            assign w_chunk      = r_shift[DATA_W-1 -: BPC];
            assign w_shift_next = r_shift << BPC;
        end

        if (REFOUT) begin : g_refout
            assign w_trans = CRC_W'(reflect(32'(r_lfsr), CRC_W)) ^ XOROUT;
        end else begin : g_norefout
            assign w_trans = r_lfsr ^ XOROUT;
        end
    endgenerate

    crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .BPC   (BPC)
    ) u_step (
        .i_crc  (r_lfsr),
        .i_bits (w_chunk),
        .o_crc  (w_lfsr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= INIT;
            r_shift     <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_crc_out   <= '0;
            r_crc_ok    <= 1'b0;
            r_crc_valid <= 1'b0;
        end else begin
            r_crc_valid <= 1'b0;
            if (clr) begin
                // Abort: discard the partial frame, keep the last published result.
                r_state <= ST_IDLE;
                r_lfsr  <= INIT;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (in_valid) begin
                            r_shift <= in_data;
                            r_last  <= in_last;
                            r_cnt   <= '0;
                            r_state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        r_lfsr  <= w_lfsr_next;
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(N - 1)) begin
                            r_state <= r_last ? ST_DONE : ST_IDLE;
                        end
                    end
                    ST_DONE: begin
                        r_crc_out   <= w_trans;
                        r_crc_ok    <= (w_trans == CHECK_RES);
                        r_crc_valid <= 1'b1;
                        r_lfsr      <= INIT;
                        r_state     <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !clr;
    assign busy      = (r_state != ST_IDLE);
    assign crc_out   = r_crc_out;
    assign crc_ok    = r_crc_ok;
    assign crc_valid = r_crc_valid;

endmodule

// File: tb/tb_crc_lfsr_engine.sv
// Directed bench for crc_lfsr_engine: three configurations share clock, rst and clr;
// a scoreboard queue holds expected CRC/ok/pulse-cycle per frame.
module tb_crc_lfsr_engine;
    import crc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [2:0]  vld, lst, rdy, cv, ok, bsy;
    logic [7:0]  dat [3];
    logic [7:0]  co_a, co_b;
    logic [15:0] co_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          dut;
        logic [15:0] crc;
        logic        ok;
        int          cyc;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] frm [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_lfsr_engine u_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]), .in_last(lst[0]),
        .crc_out(co_a), .crc_valid(cv[0]), .crc_ok(ok[0]), .busy(bsy[0])
    );

    crc_lfsr_engine #(.BPC(8)) u_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]), .in_last(lst[1]),
        .crc_out(co_b), .crc_valid(cv[1]), .crc_ok(ok[1]), .busy(bsy[1])
    );

    crc_lfsr_engine #(
        .CRC_W(16), .POLY(16'h8005), .INIT(16'h0), .REFIN(1'b1), .REFOUT(1'b1),
        .XOROUT(16'h0), .CHECK_RES(16'h0), .DATA_W(8), .BPC(4)
    ) u_c (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(dat[2]), .in_last(lst[2]),
        .crc_out(co_c), .crc_valid(cv[2]), .crc_ok(ok[2]), .busy(bsy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] obs_crc(input int d);
        case (d)
            0:       return {8'h00, co_a};
            1:       return {8'h00, co_b};
            default: return co_c;
        endcase
    endfunction

    // Every crc_valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (cv[d] === 1'b1) begin
                chk("pulse_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("pulse_dut", d, e.dut);
                    chk("crc_out", obs_crc(d), e.crc);
                    chk("crc_ok", ok[d], e.ok);
                    chk("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send_word(input int d, input logic [7:0] b, input bit last,
                             input bit hold, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        vld[d] = 1'b1;
        dat[d] = b;
        lst[d] = last;
        #1;
        while (!rdy[d] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 32'd1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        if (!hold || last) vld[d] = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [15:0] ecrc, input bit eok,
                              input int n_steps, input bit hold);
        int   acc;
        exp_t e;
        for (int i = 0; i < frm.size(); i++) begin
            send_word(d, frm[i], (i == frm.size() - 1), hold, acc);
            if (i == frm.size() - 1) begin
                e.dut = d;
                e.crc = ecrc;
                e.ok  = eok;
                e.cyc = acc + n_steps + 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic load_rom(input bit with_crc);
        frm = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
        if (with_crc) frm.push_back(8'hA2);
    endtask

    task automatic load_ascii();
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        clr = 1'b0;
        vld = '0;
        lst = '0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_crc_out", {co_a, co_b, co_c}, 32'h0);
        chk("reset_valid", cv, 3'b000);
        chk("reset_ok", ok, 3'b000);
        chk("reset_ready", rdy, 3'b111);
        chk("reset_busy", bsy, 3'b000);

        // Dallas ROM example: bad residue, then with its CRC byte appended.
        load_rom(1'b0);
        send_frame(0, 16'h00A2, 1'b0, 8, 1'b0);
        drain();
        load_rom(1'b1);
        send_frame(0, 16'h0000, 1'b1, 8, 1'b0);
        drain();

        // Abort in the middle of the third byte, then resend the whole frame.
        send_word(0, 8'h02, 1'b0, 1'b0, acc);
        send_word(0, 8'h1C, 1'b0, 1'b0, acc);
        send_word(0, 8'hB8, 1'b0, 1'b0, acc);
        repeat (3) @(negedge clk);
        chk("busy_before_clr", bsy[0], 1'b1);
        clr = 1'b1;
        #1;
        chk("ready_during_clr", rdy[0], 1'b0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("busy_after_clr", bsy[0], 1'b0);
        chk("crc_out_held", co_a, 8'h00);
        chk("crc_ok_held", ok[0], 1'b1);
        repeat (12) @(negedge clk);
        load_rom(1'b0);
        send_frame(0, 16'h00A2, 1'b0, 8, 1'b0);
        drain();

        // in_valid held high through SHIFT must still take each word once.
        load_ascii();
        send_frame(0, 16'h00A1, 1'b0, 8, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        chk("idle_after_hold", bsy[0], 1'b0);

        // Byte-per-cycle and CRC-16/ARC nibble-per-cycle variants.
        send_frame(1, 16'h00A1, 1'b0, 1, 1'b0);
        drain();
        send_frame(2, 16'hBB3D, 1'b0, 2, 1'b0);
        drain();

        // clr beats a same-cycle accept: the word must be dropped.
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 8'h55;
        lst[0] = 1'b1;
        clr    = 1'b1;
        #1;
        chk("clr_blocks_ready", rdy[0], 1'b0);
        @(negedge clk);
        chk("clr_blocks_accept", bsy[0], 1'b0);
        vld[0] = 1'b0;
        lst[0] = 1'b0;
        clr    = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset part-way through a frame.
        send_word(0, 8'h02, 1'b0, 1'b0, acc);
        send_word(0, 8'h1C, 1'b0, 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_crc_out", co_a, 8'h00);
        chk("arst_busy", bsy[0], 1'b0);
        chk("arst_ready", rdy[0], 1'b1);
        chk("arst_valid", cv[0], 1'b0);
        chk("arst_ok", ok[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        load_rom(1'b0);
        send_frame(0, 16'h00A2, 1'b0, 8, 1'b0);
        drain();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
